dmem_mmio_bridge: RTL and testbench

//  Data-side memory subsystem on the core's MEM-stage data port (address, byte-lane write enables,

---
 rtl/dmem_mmio_bridge.sv | 145 ++++++++++++++
 tb/tb_dmem_mmio_bridge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_bridge.sv
// Data-side RAM plus MMIO page (TX byte queue, optional mtime/mtimecmp timer).
// Define DMEM_MMIO_TIMER_EN to build the timer registers and timer_irq.
module dmem_mmio_bridge #(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter int unsigned TXQ_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);
    localparam int unsigned PW = $clog2(TXQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TXQ_DEPTH);

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

    logic          is_mmio;
    logic [7:0]    off;
    logic [AW-1:0] word_idx;
    logic          wr_any;
    logic          unused_addr_bits;

    assign is_mmio          = (addr[31:8] == MMIO_BASE[31:8]);
    assign off              = addr[7:0];
    assign word_idx         = addr[2 +: AW];
    assign wr_any           = |we;
    assign unused_addr_bits = &{1'b0, addr[1:0]};

    // Data RAM: asynchronous read, byte-lane write, no reset
    logic [31:0] ram [DMEM_WORDS];

    always_ff @(posedge clk) begin
        if (!rst && !is_mmio) begin
            for (int unsigned i = 0; i < 4; i++)
                if (we[i]) ram[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // TX byte queue
    logic [7:0]    txq [TXQ_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          ovf, full, pop, push_req, push_ok, ovf_clr;

    assign full     = (count == FULL_CNT);
    assign tx_valid = (count != '0);
    assign tx_data  = txq[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign push_req = is_mmio && (off == 8'h00) && we[0];
    assign push_ok  = push_req && (!full || pop);
    assign ovf_clr  = is_mmio && (off == 8'h04) && wr_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TXQ_DEPTH; i++) txq[PW'(i)] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                txq[wr_ptr] <= wdata[7:0];
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (ovf_clr) ovf <= 1'b0;
            else if (push_req && full && !pop) ovf <= 1'b1;
        end
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] mtime_lo, mtime_hi, cmp_lo, cmp_hi;
    logic [31:0] mtime_lo_nx, mtime_hi_nx;
    logic        irq_q;

    // A written half ignores the increment; HI still takes the carry out of the old LO
    always_comb begin
        mtime_lo_nx = mtime_lo + 32'd1;
        mtime_hi_nx = mtime_hi + {31'b0, &mtime_lo};
        if (is_mmio && (off == 8'h08) && wr_any) mtime_lo_nx = lane_merge(mtime_lo, wdata, we);
        if (is_mmio && (off == 8'h0C) && wr_any) mtime_hi_nx = lane_merge(mtime_hi, wdata, we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_lo <= '0;
            mtime_hi <= '0;
            cmp_lo   <= '1;
            cmp_hi   <= '1;
            irq_q    <= 1'b0;
        end else begin
            mtime_lo <= mtime_lo_nx;
            mtime_hi <= mtime_hi_nx;
            if (is_mmio && (off == 8'h10) && wr_any) cmp_lo <= lane_merge(cmp_lo, wdata, we);
            if (is_mmio && (off == 8'h14) && wr_any) cmp_hi <= lane_merge(cmp_hi, wdata, we);
            irq_q <= ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
        end
    end

    assign timer_irq = irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    logic [31:0] mmio_rdata;

    always_comb begin
        mmio_rdata = '0;
        case (off)
            8'h04:   mmio_rdata = {16'b0, 8'(count), 5'b0, ovf, full, !tx_valid};
`ifdef DMEM_MMIO_TIMER_EN
            8'h08:   mmio_rdata = mtime_lo;
            8'h0C:   mmio_rdata = mtime_hi;
            8'h10:   mmio_rdata = cmp_lo;
            8'h14:   mmio_rdata = cmp_hi;
`endif
            default: mmio_rdata = '0;
        endcase
        rdata = is_mmio ? mmio_rdata : ram[word_idx];
    end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Self-checking bench for dmem_mmio_bridge: directed steps followed by random traffic
// compared against a queue/array/64-bit-integer reference model.
module tb_dmem_mmio_bridge;

    localparam int unsigned DW = 1024;
    localparam int unsigned QD = 8;
    localparam int unsigned AW = $clog2(DW);
    localparam logic [31:0] MB = 32'h8000_0000;
    localparam logic [31:0] IDLE = MB + 32'h18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [3:0]  we = '0;
    logic [7:0]  tx_data;
    logic        tx_valid, timer_irq;
    logic        tx_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    dmem_mmio_bridge #(.DMEM_WORDS(DW), .TXQ_DEPTH(QD), .MMIO_BASE(MB)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] ram_m [int];
    logic [7:0]  q [$];
    logic        ovf_m = 1'b0;
    logic [63:0] mtime_m = '0;
    logic [63:0] cmp_m = '1;
    logic        irq_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, output bit known);
        int idx;
        known = 1'b1;
        if (a[31:8] == MB[31:8]) begin
            case (a[7:0])
                8'h04: return {16'b0, 8'(q.size()), 5'b0, ovf_m, q.size() == QD, q.size() == 0};
`ifdef DMEM_MMIO_TIMER_EN
                8'h08: return mtime_m[31:0];
                8'h0C: return mtime_m[63:32];
                8'h10: return cmp_m[31:0];
                8'h14: return cmp_m[63:32];
`endif
                default: return 32'h0;
            endcase
        end
        idx = int'(a[2 +: AW]);
        known = ram_m.exists(idx);
        return known ? ram_m[idx] : 32'h0;
    endfunction

    task automatic model_edge();
        bit mmio;
        bit pop, push;
        int idx;
        logic [7:0] off;
        logic [63:0] nxt;
        mmio = (addr[31:8] == MB[31:8]);
        off = addr[7:0];
        if (rst) begin
            q.delete();
            ovf_m = 1'b0;
            mtime_m = '0;
            cmp_m = '1;
            irq_m = 1'b0;
            return;
        end
        if (!mmio && we != 4'h0) begin
            idx = int'(addr[2 +: AW]);
            if (ram_m.exists(idx)) ram_m[idx] = merge(ram_m[idx], wdata, we);
            else if (we == 4'hF) ram_m[idx] = wdata;
        end
        pop = (q.size() != 0) && tx_ready;
        push = mmio && off == 8'h00 && we[0];
        if (push && q.size() == QD && !pop) ovf_m = 1'b1;
        if (pop) void'(q.pop_front());
        if (push && q.size() < QD) q.push_back(wdata[7:0]);
        if (mmio && off == 8'h04 && we != 4'h0) ovf_m = 1'b0;
`ifdef DMEM_MMIO_TIMER_EN
        irq_m = (mtime_m >= cmp_m);
        nxt = mtime_m + 64'd1;
        if (mmio && we != 4'h0) begin
            if (off == 8'h08) nxt[31:0]  = merge(mtime_m[31:0], wdata, we);
            if (off == 8'h0C) nxt[63:32] = merge(mtime_m[63:32], wdata, we);
            if (off == 8'h10) cmp_m[31:0]  = merge(cmp_m[31:0], wdata, we);
            if (off == 8'h14) cmp_m[63:32] = merge(cmp_m[63:32], wdata, we);
        end
        mtime_m = nxt;
`endif
    endtask

    task automatic check_outputs();
        chk("tx_valid", tx_valid, q.size() != 0);
        if (q.size() != 0) chk("tx_data", tx_data, q[0]);
        chk("timer_irq", timer_irq, irq_m);
    endtask

    // apply inputs for one cycle: check combinational rdata, clock, check registered outputs
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                         input logic rdy, input logic r);
        bit known;
        logic [31:0] e;
        addr = a; wdata = d; we = w; tx_ready = rdy; rst = r;
        #1;
        e = exp_rd(a, known);
        if (!r && known) chk("rdata", rdata, e);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic peek(input logic [31:0] a);
        bit known;
        logic [31:0] e;
        addr = a; we = 4'h0; rst = 1'b0;
        #1;
        e = exp_rd(a, known);
        if (known) chk("peek_rdata", rdata, e);
    endtask

    initial begin
        logic [31:0] offs [8];
        logic [31:0] a;
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'hFC};

        // reset
        drive(IDLE, 0, 4'h0, 1'b0, 1'b1);
        drive(IDLE, 0, 4'h0, 1'b0, 1'b1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_irq", timer_irq, 0);
        peek(MB + 32'h04);
        chk("rst_status", rdata, 32'h0000_0001);

        // RAM byte lanes and aliasing
        drive(32'h10, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
        drive(32'h10, 32'hAABB_CCDD, 4'b0011, 1'b0, 1'b0);
        peek(32'h10);
        chk("ram_lanes", rdata, 32'h1122_CCDD);
        peek(32'h10 + 4 * DW);
        chk("ram_alias", rdata, 32'h1122_CCDD);

        // TX push/pop ordering
        for (int k = 0; k < 3; k++) drive(MB, 32'h41 + k, 4'h1, 1'b0, 1'b0);
        peek(MB + 32'h04);
        chk("tx3_status", rdata, 32'h0000_0300);
        for (int k = 0; k < 2; k++) begin
            drive(IDLE, 0, 4'h0, 1'b0, 1'b0);
            chk("tx_hold", tx_data, 8'h41);
        end
        for (int k = 0; k < 3; k++) begin
            chk("tx_order", tx_data, 8'h41 + k);
            drive(IDLE, 0, 4'h0, 1'b1, 1'b0);
        end
        chk("tx_drained", tx_valid, 0);

        // TX full / overflow
        for (int k = 0; k < QD; k++) drive(MB, 32'h60 + k, 4'h1, 1'b0, 1'b0);
        peek(MB + 32'h04);
        chk("full_status", rdata, 32'h0000_0802);
        drive(MB, 32'h99, 4'h1, 1'b0, 1'b0);
        peek(MB + 32'h04);
        chk("ovf_status", rdata, 32'h0000_0806);
        drive(MB, 32'hAA, 4'h1, 1'b1, 1'b0);
        peek(MB + 32'h04);
        chk("full_pushpop", rdata, 32'h0000_0806);
        chk("full_head", tx_data, 8'h61);
        drive(MB + 32'h04, 0, 4'b0100, 1'b0, 1'b0);
        peek(MB + 32'h04);
        chk("ovf_clear", rdata, 32'h0000_0802);
        for (int k = 0; k < QD; k++) drive(IDLE, 0, 4'h0, 1'b1, 1'b0);
        chk("full_drained", tx_valid, 0);

`ifdef DMEM_MMIO_TIMER_EN
        // mtime carry and compare
        drive(MB + 32'h08, 32'hFFFF_FFFE, 4'hF, 1'b0, 1'b0);
        drive(MB + 32'h0C, 32'h0, 4'hF, 1'b0, 1'b0);
        drive(IDLE, 0, 4'h0, 1'b0, 1'b0);
        peek(MB + 32'h08);
        chk("carry_lo", rdata, 32'h0);
        peek(MB + 32'h0C);
        chk("carry_hi", rdata, 32'h1);
        drive(MB + 32'h14, 32'h1, 4'hF, 1'b0, 1'b0);
        drive(MB + 32'h10, 32'h5, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 20 && mtime_m != 64'h1_0000_0005; k++)
            drive(IDLE, 0, 4'h0, 1'b0, 1'b0);
        peek(MB + 32'h08);
        chk("cmp_reach_lo", rdata, 32'h5);
        chk("irq_not_early", timer_irq, 0);
        drive(IDLE, 0, 4'h0, 1'b0, 1'b0);
        chk("irq_rise", timer_irq, 1);
`else
        // timer absent
        drive(MB + 32'h08, 32'h1234, 4'hF, 1'b0, 1'b0);
        peek(MB + 32'h08);
        chk("notimer_lo", rdata, 32'h0);
        for (int k = 0; k < 1000; k++) drive(IDLE, 0, 4'h0, 1'b0, 1'b0);
        chk("notimer_irq", timer_irq, 0);
`endif

        // reset mid-stream
        for (int k = 0; k < 4; k++) drive(MB, 32'h51 + k, 4'h1, 1'b0, 1'b0);
        peek(MB + 32'h04);
        chk("pre_rst_count", rdata, 32'h0000_0400);
`ifdef DMEM_MMIO_TIMER_EN
        chk("pre_rst_irq", timer_irq, 1);
`endif
        drive(MB, 32'h77, 4'h1, 1'b1, 1'b1);
        chk("post_rst_valid", tx_valid, 0);
        chk("post_rst_irq", timer_irq, 0);
        peek(MB + 32'h04);
        chk("post_rst_status", rdata, 32'h0000_0001);
        peek(MB + 32'h08);
        chk("post_rst_mtime", rdata, 32'h0);
        peek(32'h10);
        chk("post_rst_ram", rdata, 32'h1122_CCDD);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] w;
            if ($urandom_range(0, 2) != 0)
                a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
            else
                a = MB | offs[$urandom_range(0, 7)];
            w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            drive(a, $urandom, w, 1'($urandom), $urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
